// File: rtl/fmul_sched.sv
// Arbitrates two requesters onto one shared single-precision multiplier with a
// fixed pipeline latency and returns each product on a shared response channel.
module fmul_sched #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_x1,
  input  logic [31:0] req0_x2,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_x1,
  input  logic [31:0] req1_x2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_y,
  output logic [31:0] mul_x1,
  output logic [31:0] mul_x2,
  input  logic [31:0] mul_y,
  output logic        busy
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       last_id;
  logic       grant0, grant1;
  logic       acc0, acc1, accept, capture;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_id);
    grant1 = req1_valid & (~req0_valid | ~last_id);
  end

  assign req0_ready = rstn & (state == IDLE) & grant0;
  assign req1_ready = rstn & (state == IDLE) & grant1;
  assign acc0       = req0_valid & req0_ready;
  assign acc1       = req1_valid & req1_ready;
  assign accept     = acc0 | acc1;
  assign capture    = (state == WAIT) && (cnt == 4'd0);
  assign rsp_valid  = (state == DONE);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (capture) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt     <= 4'd0;
      last_id <= 1'b1;
    end else if (accept) begin
      cnt     <= CNT_INIT;
      last_id <= acc1;
    end else if ((state == WAIT) && !capture) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Operands stay on the multiplier inputs until the next accept.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mul_x1 <= 32'd0;
      mul_x2 <= 32'd0;
      rsp_id <= 1'b0;
      rsp_y  <= 32'd0;
    end else begin
      if (accept) begin
        mul_x1 <= acc1 ? req1_x1 : req0_x1;
        mul_x2 <= acc1 ? req1_x2 : req0_x2;
        rsp_id <= acc1;
      end
      if (capture) rsp_y <= mul_y;
    end
  end

endmodule

// File: doc/fmul_sched.md
FMUL_SCHED -- requirements
Module: fmul_sched

Interface
REQ-001 SHALL have parameter: LATENCY, default 2, cycles from operand launch to mul_y capture; legal range 1..15.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rstn  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports: req0_valid  input  1 / req0_ready  output  1 / req0_x1  input  32 / req0_x2  input  32  requester 0 single-precision operand pair with handshake.
REQ-005 SHALL have ports: req1_valid  input  1 / req1_ready  output  1 / req1_x1  input  32 / req1_x2  input  32  requester 1, same semantics.
REQ-006 SHALL have ports: rsp_valid  output  1 / rsp_ready  input  1 / rsp_id  output  1 / rsp_y  output  32  shared result channel; rsp_id names the requester.
REQ-007 SHALL have ports: mul_x1  output  32 / mul_x2  output  32 / mul_y  input  32  connection to the shared single-precision multiplier.
REQ-008 SHALL have port: busy  output  1  high whenever an operation is in flight or a result is pending.

Function
REQ-009 SHALL implement states IDLE, WAIT, DONE; busy = (state != IDLE).
REQ-010 SHALL drive reqN_ready high only in IDLE, and only for the granted requester; at most one ready high per cycle.
REQ-011 SHALL grant in IDLE as follows: only one valid -> that requester; both valid -> the requester not equal to last_id (round-robin); none valid -> no ready.
REQ-012 SHALL accept on reqN_valid & reqN_ready at edge k: register reqN_x1/x2 into mul_x1/mul_x2, record id, set last_id = N, load counter with LATENCY-1, go to WAIT.
REQ-013 SHALL, in WAIT, decrement counter each cycle; when counter == 0, capture mul_y into rsp_y at that edge (edge k+LATENCY) and go to DONE.
REQ-014 SHALL hold mul_x1/mul_x2 stable from edge k until the next accept; values after capture are held, not cleared.
REQ-015 SHALL, in DONE, assert rsp_valid with rsp_y and rsp_id stable until rsp_ready is sampled high, then return to IDLE at that edge.
REQ-016 SHALL NOT accept a new request in the cycle of the DONE handshake; minimum issue period is LATENCY+2 cycles.
REQ-017 SHALL ignore rsp_ready outside DONE and reqN_valid outside IDLE; rsp_valid is never high outside DONE.
REQ-018 SHALL NOT require requesters to hold valid while not ready; grant is re-evaluated every IDLE cycle from current valids.
REQ-019 SHALL pass mul_y through unmodified into rsp_y; no arithmetic on the data path.
REQ-020 SHALL NOT update last_id on a cycle with no accept.

Reset
REQ-021 SHALL, when rstn is low at a rising edge, set state = IDLE, counter = 0, last_id = 1, rsp_valid = 0, rsp_id = 0, rsp_y = 0, mul_x1 = 0, mul_x2 = 0; req0_ready/req1_ready low during reset.
REQ-022 SHALL discard any in-flight or pending operation on reset; no response for it is ever produced.
REQ-023 SHALL, on the first cycle after reset with both valids high, grant requester 0 (last_id = 1).

Verification
REQ-024 SHALL cover single op: LATENCY=2, req0 x1=0x40000000, x2=0x40400000 accepted at edge k -> rsp_valid at edge k+2, rsp_y=0x40C00000, rsp_id=0.
REQ-025 SHALL cover contention: both valid continuously, req1 x1=x2=0x3FC00000 -> grants alternate 0,1,0,1; req1 responses rsp_y=0x40100000, rsp_id=1; accepts spaced LATENCY+2 cycles.
REQ-026 SHALL cover backpressure: rsp_ready low 5 cycles in DONE -> rsp_y/rsp_id stable, both reqN_ready low, no accept until cycle after handshake.
REQ-027 SHALL cover reset mid-WAIT: rstn low for 1 edge during WAIT -> state IDLE, rsp_valid never asserted for that op, next tie grants req0.
REQ-028 SHALL cover LATENCY=1: accept at edge k -> capture at edge k+1; with LATENCY=15 -> capture at edge k+15; valid dropped while not ready -> no accept, last_id unchanged.
